memory_stage: RTL and testbench
===============================

# memory_stage

Load/store stage directly downstream of the execute stage in the mriscv pipeline. It takes the execute result (ALU value or effective address), the register destination, the store data and `func3`. It runs data-memory transactions over a req/gnt + rvalid handshake, aligns and sign- or zero-extends load data, and delivers one writeback beat per retired instruction to the register file. While a memory transaction is outstanding it back-pressures execute through `in_ready`.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute outputs valid this cycle
- in_ready  out  1  stage accepts an instruction this cycle
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- func3  in  3  width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr_result  in  32  effective address (load/store) or ALU/jump result
- store_data  in  32  rs2 value for stores
- dest_i  in  5  destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  writeback beat, one cycle
- wb_dest  out  5  writeback register
- wb_data  out  32  writeback value
- access_err  out  1  one-cycle pulse: misaligned access or illegal func3

## Operation
- FSM states: IDLE, REQ, WAIT_R. Reset state is IDLE.
- `in_ready` = (state == IDLE) && !reset.
- **IDLE, in_valid=0:** no action.
- **IDLE, in_valid, neither load nor store:** next cycle wb_valid=1, wb_data=addr_result, wb_dest=dest_i. State stays IDLE.
- **IDLE, load/store, legal and aligned:**
  - Latch dest_i, func3, addr_result[1:0] and load/store type.
  - Next cycle drive mem_req=1, mem_we=is_store, mem_addr={addr[31:2],2'b00}. Enter REQ.
- **Legality:**
  - Loads accept func3 ∈ {000,001,010,100,101}. Stores accept {000,001,010}.
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - A violation pulses access_err next cycle, issues no request and no wb_valid. State stays IDLE.
- **Store lanes:**
  - sb: wstrb = 4'b0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - sh: wstrb = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - sw: wstrb = 1111, wdata = sd.
- **Loads:** wstrb = 0000.
- **REQ:** mem_req and all mem_* outputs are held stable until mem_gnt=1. On the gnt cycle:
  - Store: next cycle mem_req=0, state IDLE, no wb_valid.
  - Load: next cycle mem_req=0, state WAIT_R.
- **WAIT_R:** wait indefinitely for mem_rvalid. On rvalid, next cycle wb_valid=1, wb_dest=latched dest, wb_data = extracted value. State IDLE.
- **Extraction:** byte = rdata[8*a+7 : 8*a], a = addr[1:0]; half = addr[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend. lbu/lhu zero-extend. lw passes rdata unchanged.
- mem_rvalid in IDLE or REQ is ignored.
- mem_gnt outside REQ is ignored.
- dest_i = 0 is passed through unchanged; the register file discards x0 writes.

## Timing
- All outputs are registered except in_ready.
- **Reset values:** mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, wb_dest=0, wb_data=0, access_err=0, in_ready=0 while reset is high.
- **Latency, accept at cycle T:**
  - Pass-through: wb_valid at T+1.
  - Load with immediate gnt and rvalid: mem_req at T+1, gnt at T+1, rvalid at T+2, wb_valid at T+3.
  - Store with immediate gnt: mem_req at T+1 only. in_ready returns at T+2.
- Back-to-back pass-through instructions sustain one per cycle.
- wb_valid and access_err are high for exactly one cycle per event.
- **Reset mid-transaction** (REQ or WAIT_R): state goes to IDLE and mem_req drops the cycle after reset. A late rvalid after reset is ignored.

## Test plan
- **ALU pass-through:** in_valid, addr_result=0x0000_1234, dest_i=5, 3 consecutive cycles -> wb_valid on 3 consecutive cycles, wb_dest=5, wb_data=0x1234, mem_req never asserted.
- **Load lb, sign-extended:** addr=0x103, gnt delayed 2 cycles, rdata=0x80FF_FF7F -> mem_addr=0x100, req held 3 cycles, wb_data=0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
- **Store sh:** addr=0x202, store_data=0xAAAA_BEEF -> mem_we=1, mem_addr=0x200, wstrb=1100, wdata=0xBEEF_BEEF, no wb_valid, in_ready=0 until the gnt cycle +1.
- **Misaligned and illegal:**
  - lw at 0x001 -> access_err one cycle, no mem_req, no wb_valid.
  - Store with func3=100 -> same response.
- **Reset in WAIT_R:** issue lw, grant it, assert reset before rvalid, then rvalid 2 cycles later -> no wb_valid, all outputs 0, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory bus between the load/store stage (master) and the memory (slave):
// req/gnt request phase followed by an rvalid read-return phase.
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Load/store stage after execute: issues data-memory transactions, aligns and
// extends load data, and produces one writeback beat per retired instruction.
//
// state  | meaning
// IDLE   | ready for an instruction from execute
// REQ    | mem_req held with stable bus outputs until mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
module memory_stage (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           func3,
  input  logic [31:0]          addr_result,
  input  logic [31:0]          store_data,
  input  logic [4:0]           dest_i,
  memory_stage_if.master       mem,
  output logic                 wb_valid,
  output logic [4:0]           wb_dest,
  output logic [31:0]          wb_data,
  output logic                 access_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        access_err_q, access_err_d;
  logic [4:0]  dest_q, dest_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  off_q, off_d;

  logic [1:0]  off;
  logic        is_mem;
  logic        func_ok;
  logic        align_ok;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign off    = addr_result[1:0];
  assign is_mem = is_load | is_store;

  // Unsigned widths (bu/hu) exist only for loads.
  always_comb begin
    func_ok  = 1'b0;
    align_ok = 1'b0;
    case (func3)
      3'b000: begin func_ok = 1'b1;      align_ok = 1'b1;        end
      3'b001: begin func_ok = 1'b1;      align_ok = ~off[0];     end
      3'b010: begin func_ok = 1'b1;      align_ok = (off == 2'b00); end
      3'b100: begin func_ok = ~is_store; align_ok = 1'b1;        end
      3'b101: begin func_ok = ~is_store; align_ok = ~off[0];     end
      default: begin func_ok = 1'b0;     align_ok = 1'b0;        end
    endcase
  end

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'd0;
    if (is_store) begin
      case (func3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << off;
          st_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          st_wstrb = off[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{store_data[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem.mem_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (func3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    wb_valid_d   = 1'b0;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    access_err_d = 1'b0;
    dest_d       = dest_q;
    func3_d      = func3_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_i;
            wb_data_d  = addr_result;
          end else if (!(func_ok && align_ok)) begin
            access_err_d = 1'b1;
          end else begin
            dest_d      = dest_i;
            func3_d     = func3;
            off_d       = off;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr_result[31:2], 2'b00};
            mem_wstrb_d = st_wstrb;
            mem_wdata_d = st_wdata;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? IDLE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (mem.mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_dest_d  = dest_q;
          wb_data_d  = ld_value;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_dest_q    <= 5'd0;
      wb_data_q    <= 32'd0;
      access_err_q <= 1'b0;
      dest_q       <= 5'd0;
      func3_q      <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      wb_valid_q   <= wb_valid_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
      access_err_q <= access_err_d;
      dest_q       <= dest_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
    end
  end

  assign in_ready      = (state_q == IDLE) && !reset;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_dest       = wb_dest_q;
  assign wb_data       = wb_data_q;
  assign access_err    = access_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases with literal expectations, then random
// traffic against a transaction-level model with a randomized memory responder.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, is_load, is_store;
  logic [2:0]  func3;
  logic [31:0] addr_result, store_data;
  logic [4:0]  dest_i;
  logic        wb_valid, access_err;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  memory_stage_if mem_if();

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .func3(func3),
    .addr_result(addr_result), .store_data(store_data), .dest_i(dest_i),
    .mem(mem_if), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] dest; logic [31:0] data;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {logic [4:0] dest; logic [2:0] f3; logic [1:0] off;} ld_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  ld_t  pend_ld[$];

  int total = 0, bad = 0;
  int pending_err = 0, wb_seen = 0, req_len = 0;
  logic [31:0] last_wb_data = 0, last_addr = 0, last_wdata = 0;
  logic [3:0]  last_wstrb = 0;
  logic        last_we = 0;
  bit fixed_mode = 1, resp_busy = 0, rst_evt = 0;
  int gnt_dly = 0, rv_dly = 0;
  logic [31:0] rdata_fix = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Access size in bytes for this func3, 0 when the code is not allowed.
  function automatic int acc_size(bit st, logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return st ? 0 : 1;
      3'd5: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(logic [2:0] f3, logic [1:0] off, logic [31:0] rd);
    int sz;
    longint raw;
    sz  = acc_size(1'b0, f3);
    raw = longint'(rd) >> (8 * int'(off));
    if (sz < 4) begin
      raw = raw % (longint'(1) << (8 * sz));
      if (!f3[2] && raw >= (longint'(1) << (8 * sz - 1)))
        raw = raw - (longint'(1) << (8 * sz)) + (longint'(1) << 32);
    end
    return raw[31:0];
  endfunction

  task automatic send(input bit ld, input bit st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
    int g;
    int sz;
    req_t r;
    g = 0;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    chk("ready_wait", 72'(g < 200), 1);
    in_valid = 1; is_load = ld; is_store = st; func3 = f3;
    addr_result = a; store_data = sd; dest_i = d;
    sz = acc_size(st, f3);
    if (!ld && !st) exp_wb.push_back(wb_t'{d, a});
    else if (sz == 0 || (a % sz) != 0) pending_err++;
    else begin
      r.we    = st;
      r.addr  = a & ~32'd3;
      r.wstrb = st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'd0;
      r.wdata = 32'd0;
      if (st) for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = sd[8*(k % sz) +: 8];
      exp_req.push_back(r);
      if (ld) pend_ld.push_back(ld_t'{d, f3, a[1:0]});
    end
    @(negedge clk);
    in_valid = 0; is_load = 1'($urandom); is_store = 1'($urandom);
    func3 = 3'($urandom); addr_result = $urandom; store_data = $urandom; dest_i = 5'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_wb.size() != 0 || exp_req.size() != 0 || pend_ld.size() != 0 ||
            resp_busy || pending_err != 0) && g < 300) begin
      @(negedge clk); g++;
    end
    chk("drain", 72'(g < 300), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string n);
    chk({n, "_mem"}, {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb}, 0);
    chk({n, "_wb"}, {wb_valid, wb_dest, wb_data, access_err, in_ready}, 0);
  endtask

  // Compare process: every writeback and error pulse must match the model.
  initial forever begin
    @(negedge clk);
    if (wb_valid) begin
      wb_t e;
      wb_seen++;
      last_wb_data = wb_data;
      chk("wb_expected", 72'(exp_wb.size() > 0), 1);
      if (exp_wb.size() > 0) begin
        e = exp_wb.pop_front();
        chk("wb_dest", wb_dest, e.dest);
        chk("wb_data", wb_data, e.data);
      end
    end
    if (access_err) begin
      chk("err_expected", 72'(pending_err > 0), 1);
      if (pending_err > 0) pending_err--;
    end
  end

  // Memory responder: checks each request against the model and answers it.
  initial begin
    mem_if.mem_gnt = 0; mem_if.mem_rvalid = 0; mem_if.mem_rdata = 0;
    forever begin
      @(negedge clk);
      resp_busy = 0; mem_if.mem_gnt = 0; mem_if.mem_rvalid = 0;
      if (mem_if.mem_req && !reset) begin
        req_t cap, e;
        ld_t  l;
        int   gd, rd;
        bit   abort;
        resp_busy = 1; rst_evt = 0;
        cap = req_t'{mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb};
        chk("req_expected", 72'(exp_req.size() > 0), 1);
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          chk("req_we", cap.we, e.we);
          chk("req_addr", cap.addr, e.addr);
          chk("req_wstrb", cap.wstrb, e.wstrb);
          if (e.we) chk("req_wdata", cap.wdata, e.wdata);
        end
        last_we = cap.we; last_addr = cap.addr; last_wdata = cap.wdata; last_wstrb = cap.wstrb;
        req_len = 1;
        gd = fixed_mode ? gnt_dly : int'($urandom_range(0, 3));
        repeat (gd) begin
          if (!fixed_mode) mem_if.mem_rvalid = 1'($urandom);
          @(negedge clk);
          mem_if.mem_rvalid = 0;
          req_len++;
          chk("req_hold", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb},
              {1'b1, cap.we, cap.addr, cap.wdata, cap.wstrb});
        end
        mem_if.mem_gnt = 1;
        @(negedge clk);
        mem_if.mem_gnt = 0;
        chk("req_drop", mem_if.mem_req, 0);
        if (!cap.we) begin
          abort = 0;
          l = ld_t'{5'd0, 3'd0, 2'd0};
          if (pend_ld.size() > 0) l = pend_ld.pop_front();
          rd = fixed_mode ? rv_dly : int'($urandom_range(0, 3));
          repeat (rd) begin
            if (!fixed_mode) mem_if.mem_gnt = 1'($urandom);
            @(negedge clk);
            mem_if.mem_gnt = 0;
            if (reset || rst_evt) abort = 1;
          end
          if (reset || rst_evt) abort = 1;
          mem_if.mem_rdata  = fixed_mode ? rdata_fix : $urandom;
          mem_if.mem_rvalid = 1;
          if (!abort) exp_wb.push_back(wb_t'{l.dest, load_val(l.f3, l.off, mem_if.mem_rdata)});
        end
      end else if (!fixed_mode) begin
        mem_if.mem_gnt    = 1'($urandom);
        mem_if.mem_rvalid = 1'($urandom);
        mem_if.mem_rdata  = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int w0;
    reset = 1; in_valid = 0; is_load = 0; is_store = 0; func3 = 0;
    addr_result = 0; store_data = 0; dest_i = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // Model anchors with hand-computed values.
    chk("model_lb", load_val(3'b000, 2'd3, 32'h80FF_FF7F), 32'hFFFF_FF80);
    chk("model_lhu", load_val(3'b101, 2'd2, 32'h80FF_FF7F), 32'h0000_80FF);

    // ALU pass-through, three back to back.
    w0 = wb_seen;
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd5);
      chk("pt_wb_valid", wb_valid, 1);
      chk("pt_wb", {wb_dest, wb_data}, {5'd5, 32'h0000_1234});
    end
    drain();
    chk("pt_count", wb_seen - w0, 3);

    // lb / lbu at 0x103 with grant delayed by two cycles.
    gnt_dly = 2; rv_dly = 0; rdata_fix = 32'h80FF_FF7F;
    send(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd7);
    drain();
    chk("lb_addr", last_addr, 32'h0000_0100);
    chk("lb_req_len", req_len, 3);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    send(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd7);
    drain();
    chk("lbu_data", last_wb_data, 32'h0000_0080);

    // lw with immediate grant and rvalid: writeback three cycles after accept.
    gnt_dly = 0; rdata_fix = 32'h1234_5678;
    send(1, 0, 3'b010, 32'h0000_0040, 32'd0, 5'd2);
    chk("lw_req_t1", mem_if.mem_req, 1);
    @(negedge clk);
    chk("lw_t2", {mem_if.mem_req, wb_valid}, 0);
    @(negedge clk);
    chk("lw_wb_t3", {wb_valid, wb_data}, {1'b1, 32'h1234_5678});
    drain();

    // sh at 0x202.
    w0 = wb_seen;
    send(0, 1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9);
    chk("sh_busy_t1", {in_ready, mem_if.mem_req}, {1'b0, 1'b1});
    @(negedge clk);
    chk("sh_ready_t2", {in_ready, mem_if.mem_req}, {1'b1, 1'b0});
    drain();
    chk("sh_we", last_we, 1);
    chk("sh_addr", last_addr, 32'h0000_0200);
    chk("sh_wstrb", last_wstrb, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    chk("sh_no_wb", wb_seen - w0, 0);

    // Misaligned lw and illegal store func3.
    send(1, 0, 3'b010, 32'h0000_0001, 32'd0, 5'd3);
    chk("lw_mis_err", {access_err, mem_if.mem_req, wb_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("lw_mis_pulse", access_err, 0);
    send(0, 1, 3'b100, 32'h0000_0300, 32'h5555_5555, 5'd3);
    chk("st_ill_err", {access_err, mem_if.mem_req, wb_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("st_ill_pulse", access_err, 0);
    drain();

    // Reset while a granted load waits for rvalid; the late rvalid is dropped.
    w0 = wb_seen; rv_dly = 5; rdata_fix = 32'hDEAD_BEEF;
    send(1, 0, 3'b010, 32'h0000_0080, 32'd0, 5'd4);
    @(negedge clk);
    chk("wr_waiting", {mem_if.mem_req, in_ready}, 0);
    rst_evt = 1; reset = 1;
    @(negedge clk);
    check_zero("rst_wait_r");
    reset = 0;
    @(negedge clk);
    chk("wr_ready", in_ready, 1);
    drain();
    chk("wr_no_wb", wb_seen - w0, 0);

    // Random traffic with random grant/rvalid latency and bus noise.
    fixed_mode = 0;
    repeat (400) begin
      int op;
      op = int'($urandom_range(0, 2));
      send(op == 1, op == 2, 3'($urandom), $urandom, $urandom, 5'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    drain();
    chk("end_wb_queue", exp_wb.size(), 0);
    chk("end_err_pending", pending_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
